// File: rtl/mul4_pkg.sv
// rtl/mul4_pkg.sv - shared types and constants for the sequential 4x4 multiplier
package mul4_pkg;

  localparam int WIDTH  = 4;
  localparam int PROD_W = 8;
  localparam int STEPS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder4.sv
// rtl/adder4.sv - 4-bit ripple-carry adder used for the per-cycle partial-sum add
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/mul4_seq.sv
// rtl/mul4_seq.sv - sequential 4x4 unsigned shift-and-add multiplier around adder4
module mul4_seq #(
  parameter int WIDTH = mul4_pkg::WIDTH,
  parameter int STEPS = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import mul4_pkg::*;

  // adder4 is fixed-width, and the iteration count is tied to the operand width
  if (WIDTH != 4) begin : g_width_chk
    $error("mul4_seq: WIDTH must be 4");
  end
  if (STEPS != WIDTH) begin : g_steps_chk
    $error("mul4_seq: STEPS must equal WIDTH");
  end

  localparam int ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         count_q, count_d;
  logic [ACC_W-1:0]   product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [ACC_W-1:0]   acc_shift;

  // Partial product: add the multiplicand only when the current multiplier bit is set
  assign add_b = acc_q[0] ? mcand_q : '0;

  adder4 u_adder4 (
    .a    (acc_q[ACC_W-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The carry-out is kept by shifting it into the top bit of the accumulator
  assign acc_shift = {add_cout, add_sum, acc_q[WIDTH-1:1]};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          count_d = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_shift;
        count_d = count_q + 2'd1;
        if (count_q == 2'(STEPS - 1)) begin
          product_d = acc_shift;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= 2'd0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul4_seq.sv
// tb/tb_mul4_seq.sv - self-checking bench for mul4_seq against an arithmetic reference
module tb_mul4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  mul4_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One multiply: start edge, 4 CALC cycles, 1 DONE cycle, then held product in IDLE.
  // noisy scrambles a/b and start while busy; restart re-pulses start with 2*2 mid-CALC.
  task automatic do_mul(input logic [3:0] ea, input logic [3:0] eb,
                        input bit noisy, input bit restart, input string tag);
    logic [7:0] exp_p;
    exp_p = ea * eb;
    a = ea;
    b = eb;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({tag, " busy_calc"}, busy, 1);
      check({tag, " done_calc"}, done, 0);
      if (noisy) begin
        a = 4'($urandom);
        b = 4'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      if (restart && k == 1) begin
        a = 4'd2;
        b = 4'd2;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check({tag, " done_pulse"}, done, 1);
    check({tag, " busy_done"}, busy, 1);
    check({tag, " product"}, product, exp_p);
    tick();
    check({tag, " done_low"}, done, 0);
    check({tag, " busy_low"}, busy, 0);
    check({tag, " product_held"}, product, exp_p);
    tick();
    check({tag, " still_idle"}, busy | done, 0);
    check({tag, " product_held2"}, product, exp_p);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_product", product, 0);
      tick();
    end

    do_mul(4'd13, 4'd11, 1'b0, 1'b0, "13x11");
    do_mul(4'd15, 4'd15, 1'b0, 1'b0, "15x15");
    do_mul(4'd0,  4'd9,  1'b0, 1'b0, "0x9");
    do_mul(4'd7,  4'd0,  1'b0, 1'b0, "7x0");
    do_mul(4'd1,  4'd1,  1'b0, 1'b0, "1x1");
    do_mul(4'd5,  4'd6,  1'b0, 1'b1, "5x6_restart");

    // Reset during the second CALC cycle of 9*9
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_product", product, 0);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_done", done, 0);
      tick();
    end
    do_mul(4'd3, 4'd4, 1'b0, 1'b0, "3x4_after_rst");

    for (int i = 0; i < 20; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom);
      rb = 4'($urandom);
      do_mul(ra, rb, 1'b1, 1'b0, "random");
    end

    // Back-to-back: start held high, one result every 6 cycles
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    tick();
    for (int n = 0; n < 18; n++) begin
      check("b2b_done", done, ((n % 6) == 4) ? 1 : 0);
      check("b2b_busy", busy, ((n % 6) == 5) ? 0 : 1);
      if ((n % 6) == 4) check("b2b_product", product, 8'h2A);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul4_seq.md
Name: mul4_seq

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier.
- Sits directly upstream of and around the team's 4-bit ripple-carry adder `adder4`: it feeds `adder4` one partial-product operand pair per cycle and consumes its sum and carry-out.
- Used as the "sequential datapath" stage that follows the combinational adder lab block.
- Start/busy/done handshake toward the surrounding test or control logic.

Parameters:
- WIDTH, 4, operand width. Only 4 is legal because `adder4` is fixed-width. Elaboration fails (static assertion) if WIDTH != 4.
- STEPS, WIDTH, number of add/shift iterations. Derived value; must not be overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to multiply. Sampled only in IDLE.
- a  input  4  multiplicand. Captured on an accepted start.
- b  input  4  multiplier. Captured on an accepted start.
- busy  output  1  high while in CALC or DONE.
- done  output  1  one-cycle pulse; product is valid in that cycle.
- product  output  8  result. Held stable from done until the next accepted start.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, product=8'h00, count=0, internal registers cleared. Reset wins over every other event, including mid-CALC; a partial result is discarded.
- State machine IDLE -> CALC -> DONE -> IDLE.
- IDLE: if start=1 at an edge, capture mcand<=a, acc<={4'b0, b} (8-bit: hi nibble = running sum, lo nibble = multiplier), count<=0, go to CALC. start=0 keeps IDLE and keeps product.
- CALC, one iteration per cycle:
  - `adder4` inputs are A=acc[7:4], B=(acc[0] ? mcand : 4'b0), cin=0.
  - Next acc = {cout, S, acc[3:1]}, i.e. a right shift by 1 with the carry entering bit 7.
  - count increments. After the 4th iteration (count reaches 3 at that edge), go to DONE and load product<=next acc.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+4, i.e. 5 cycles from the start edge to the done cycle. Throughput: one multiply per 6 cycles.
- start while busy (CALC or DONE) is ignored: no capture, no restart.
- Back-to-back: start may be high in the first IDLE cycle after DONE and is accepted there.
- Arithmetic: unsigned. The 8-bit result never overflows (max 15*15=225). The adder carry-out is never dropped; it shifts into bit 7.
- a/b changing during CALC has no effect (operands are latched).
- done and busy are registered outputs (no combinational path from start).

Decomposition:
- Shared package `mul4_pkg`:
  - state enum {IDLE, CALC, DONE} (2-bit)
  - localparam WIDTH=4, PROD_W=8, STEPS=4
- Sub-module: one instance of the existing `adder4` for the per-cycle partial-sum add. No other sub-modules; the FSM, counter and shift register stay in `mul4_seq`.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> busy=0, done=0, product=0x00 for 10 cycles.
- a=13, b=11, start pulse -> done high exactly 5 cycles after the start edge, product=0x8F (143), busy high 5 cycles.
- Corners, each in sequence: a=15,b=15 -> 0xE1; a=0,b=9 -> 0x00; a=7,b=0 -> 0x00; a=1,b=1 -> 0x01. Each result is held after done.
- start re-pulsed with a=2,b=2 during CALC of 5*6 -> ignored; product=0x1E; exactly one done pulse.
- rst asserted in the 2nd CALC cycle of 9*9 -> next cycle busy=0, done=0, product=0x00. A subsequent 3*4 gives 0x0C.
- Back-to-back: start held high continuously with a=6,b=7 -> done pulses every 6 cycles, product=0x2A each time.
